// File: rtl/cfu_simd_mac_pipe_if.sv
// ============================================================================
// Module      : cfu_simd_mac_pipe_if
// Description : CFU command/response bus between the CPU and the SIMD MAC
//               unit. The CPU side uses the master modport, the CFU uses
//               the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cfu_simd_mac_pipe_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        output rsp_valid,
        input  rsp_ready,
        output rsp_payload_outputs_0
    );
endinterface

`default_nettype wire

// File: rtl/cfu_simd_mac_pipe.sv
// ============================================================================
// Module      : cfu_simd_mac_pipe
// Description : 4-lane signed int8 SIMD multiply-accumulate CFU with input
//               offset, NUM_ACC accumulator banks and a PIPE_STAGES-cycle
//               MAC latency. One command outstanding at a time; the
//               response is held until the CPU accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cfu_simd_mac_pipe #(
    parameter int NUM_ACC     = 4,
    parameter int ACC_W       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cfu_simd_mac_pipe_if.slave   bus
);

    localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int CNT_W = (PIPE_STAGES > 1) ? $clog2(PIPE_STAGES + 1) : 1;

    localparam logic [6:0] c_op_set_offset = 7'd0;
    localparam logic [6:0] c_op_clear      = 7'd1;
    localparam logic [6:0] c_op_mac        = 7'd2;
    localparam logic [6:0] c_op_read       = 7'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic signed [8:0]   r_offset;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic [SEL_W-1:0]    r_sel;
    logic [31:0]         r_rsp_data;
    logic [ACC_W-1:0]    r_acc [NUM_ACC];

    logic [6:0]          w_funct7;
    logic [SEL_W-1:0]    w_sel;
    logic signed [9:0]   w_lane [4];
    logic signed [17:0]  w_prod [4];
    logic signed [19:0]  w_sum;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_unused_funct3;

    // Accumulator value presented on the 32-bit response bus.
    function automatic logic [31:0] f_ext32(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction

    assign w_funct7        = bus.cmd_payload_function_id[9:3];
    assign w_unused_funct3 = ^bus.cmd_payload_function_id[2:0];

    // Bank select is funct3 modulo the (power-of-two) bank count.
    if (NUM_ACC > 1) begin : g_sel_multi
        assign w_sel = bus.cmd_payload_function_id[SEL_W-1:0];
    end else begin : g_sel_single
        assign w_sel = 1'b0;
    end

    // Lane datapath works on the operands captured at accept; the offset
    // cannot change while a MAC is in flight, so it is used directly.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_lane[i] = 10'($signed(r_op_a[8*i +: 8])) + 10'(r_offset);
        assign w_prod[i] = 18'(w_lane[i]) * 18'($signed(r_op_b[8*i +: 8]));
    end

    assign w_sum      = 20'(w_prod[0]) + 20'(w_prod[1])
                      + 20'(w_prod[2]) + 20'(w_prod[3]);
    assign w_acc_next = r_acc[r_sel] + ACC_W'(w_sum);

    assign bus.cmd_ready             = (r_state == S_IDLE);
    assign bus.rsp_valid             = (r_state == S_RESP);
    assign bus.rsp_payload_outputs_0 = r_rsp_data;

    // Command decode, MAC latency counter, accumulator banks and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_offset   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_sel      <= '0;
            r_rsp_data <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (w_funct7)
                            c_op_set_offset: begin
                                r_offset   <= $signed(bus.cmd_payload_inputs_0[8:0]);
                                r_rsp_data <= '0;
                                r_state    <= S_RESP;
                            end
                            c_op_clear: begin
                                if (bus.cmd_payload_inputs_0[31]) begin
                                    for (int i = 0; i < NUM_ACC; i++) begin
                                        r_acc[i] <= '0;
                                    end
                                end else begin
                                    r_acc[w_sel] <= '0;
                                end
                                r_rsp_data <= '0;
                                r_state    <= S_RESP;
                            end
                            c_op_mac: begin
                                r_op_a  <= bus.cmd_payload_inputs_0;
                                r_op_b  <= bus.cmd_payload_inputs_1;
                                r_sel   <= w_sel;
                                r_count <= CNT_W'(PIPE_STAGES);
                                r_state <= S_BUSY;
                            end
                            c_op_read: begin
                                r_rsp_data <= f_ext32(r_acc[w_sel]);
                                r_state    <= S_RESP;
                            end
                            default: begin
                                r_rsp_data <= '0;
                                r_state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    // Last latency cycle commits the sum and the response together.
                    if (r_count == CNT_W'(1)) begin
                        r_acc[r_sel] <= w_acc_next;
                        r_rsp_data   <= f_ext32(w_acc_next);
                        r_state      <= S_RESP;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cfu_simd_mac_pipe.sv
// ============================================================================
// Module      : tb_cfu_simd_mac_pipe
// Description : Self-checking bench for cfu_simd_mac_pipe with directed
//               scenarios and randomized commands against an arithmetic
//               reference model of the accumulator banks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cfu_simd_mac_pipe;

    localparam int P = 2;

    logic clk;
    logic reset;
    cfu_simd_mac_pipe_if bus ();

    cfu_simd_mac_pipe #(
        .NUM_ACC     (4),
        .ACC_W       (32),
        .PIPE_STAGES (P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: four 32-bit banks and the signed input offset.
    logic signed [31:0] m_acc [4];
    int                 m_off;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] fid(input int op, input int sel);
        return {7'(op), 3'(sel)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        m_off = 0;
    endfunction

    // Applies one command to the reference state and returns the expected response.
    function automatic logic [31:0] model_exec(input logic [9:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        int op;
        int sel;
        int s;
        op  = int'(f[9:3]);
        sel = int'(f[2:0]) % 4;
        case (op)
            0: begin
                m_off = int'($signed(a[8:0]));
                return 32'd0;
            end
            1: begin
                if (a[31]) begin
                    for (int i = 0; i < 4; i++) m_acc[i] = '0;
                end else begin
                    m_acc[sel] = '0;
                end
                return 32'd0;
            end
            2: begin
                s = 0;
                for (int i = 0; i < 4; i++)
                    s += (int'($signed(a[8*i +: 8])) + m_off) * int'($signed(b[8*i +: 8]));
                m_acc[sel] = m_acc[sel] + s;
                return m_acc[sel];
            end
            3: return m_acc[sel];
            default: return 32'd0;
        endcase
    endfunction

    // Drives one command, waits (bounded) for the response, holds rsp_ready low
    // for 'hold' cycles, then accepts it. lat = 64 means no response arrived.
    task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] data, output int lat);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = f;
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.rsp_payload_outputs_0;
        if (bus.rsp_valid === 1'b1) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
        end
        n_cmp++;
        if (bus.rsp_payload_outputs_0 !== 32'd0) begin
            n_fail++; $display("FAIL reset_payload: got %h expected 0", bus.rsp_payload_outputs_0);
        end
        do_cmd(fid(3, 0), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL reset_read0: got %h expected 0", d);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL reset_read_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_mac_offset();
        logic [31:0] d;
        int          lat;
        void'(model_exec(fid(2, 0), 32'h01020304, 32'h01010101));
        do_cmd(fid(2, 0), 32'h01020304, 32'h01010101, 0, d, lat);
        n_cmp++;
        if (d !== 32'd10) begin
            n_fail++; $display("FAIL mac_off0_first: got %h expected %h", d, 32'd10);
        end
        n_cmp++;
        if (lat !== P + 1) begin
            n_fail++; $display("FAIL mac_latency: got %0d expected %0d", lat, P + 1);
        end
        void'(model_exec(fid(2, 0), 32'hFFFFFFFF, 32'h01010101));
        do_cmd(fid(2, 0), 32'hFFFFFFFF, 32'h01010101, 0, d, lat);
        n_cmp++;
        if (d !== 32'd6) begin
            n_fail++; $display("FAIL mac_off0_neg: got %h expected %h", d, 32'd6);
        end
        void'(model_exec(fid(0, 0), 32'd128, 32'd0));
        do_cmd(fid(0, 0), 32'd128, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0 || lat !== 1) begin
            n_fail++; $display("FAIL set_offset_rsp: got %h/%0d expected 0/1", d, lat);
        end
        void'(model_exec(fid(2, 1), 32'h80808080, 32'h05050505));
        do_cmd(fid(2, 1), 32'h80808080, 32'h05050505, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL mac_off128_zero: got %h expected 0", d);
        end
        void'(model_exec(fid(2, 1), 32'h7F7F7F7F, 32'h7F7F7F7F));
        do_cmd(fid(2, 1), 32'h7F7F7F7F, 32'h7F7F7F7F, 0, d, lat);
        n_cmp++;
        if (d !== 32'h0001FA04) begin
            n_fail++; $display("FAIL mac_off128_max: got %h expected %h", d, 32'h0001FA04);
        end
        do_cmd(fid(3, 0), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd6) begin
            n_fail++; $display("FAIL read_acc0_kept: got %h expected %h", d, 32'd6);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, d, exp;
        int          lat;
        a   = $urandom;
        b   = $urandom;
        exp = model_exec(fid(2, 1), a, b);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = fid(2, 1);
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== P + 1 || bus.rsp_payload_outputs_0 !== exp) begin
            n_fail++; $display("FAIL bp_first_rsp: got %h lat %0d expected %h lat %0d",
                               bus.rsp_payload_outputs_0, lat, exp, P + 1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.cmd_valid               = 1'b1;
                bus.cmd_payload_function_id = fid(2, 1);
                bus.cmd_payload_inputs_0    = 32'h7F7F7F7F;
                bus.cmd_payload_inputs_1    = 32'h7F7F7F7F;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", k, bus.rsp_valid);
            end
            n_cmp++;
            if (bus.rsp_payload_outputs_0 !== exp) begin
                n_fail++; $display("FAIL bp_payload_stable[%0d]: got %h expected %h",
                                   k, bus.rsp_payload_outputs_0, exp);
            end
            n_cmp++;
            if (bus.cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_cmd_ready[%0d]: got %b expected 0", k, bus.cmd_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        // rsp_ready left high while idle must not produce anything
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_idle_after: got valid %b ready %b expected 0 1",
                               bus.rsp_valid, bus.cmd_ready);
        end
        bus.rsp_ready = 1'b0;
        do_cmd(fid(3, 1), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== m_acc[1]) begin
            n_fail++; $display("FAIL bp_ignored_cmd: got %h expected %h", d, m_acc[1]);
        end
    endtask

    task automatic test_wrap_clear();
        logic [31:0] d, exp;
        int          lat;
        int          bad;
        void'(model_exec(fid(1, 0), 32'h80000000, 32'd0));
        do_cmd(fid(1, 0), 32'h80000000, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL clear_all_rsp: got %h expected 0", d);
        end
        do_cmd(fid(3, 1), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL clear_all_bank1: got %h expected 0", d);
        end
        // Offset -256 with all lanes -128 adds 196608 per MAC, crossing 2^31 at step 10923.
        void'(model_exec(fid(0, 0), 32'h00000100, 32'd0));
        do_cmd(fid(0, 0), 32'h00000100, 32'd0, 0, d, lat);
        bad = 0;
        for (int i = 0; i < 10923; i++) begin
            exp = model_exec(fid(2, 2), 32'h80808080, 32'h80808080);
            do_cmd(fid(2, 2), 32'h80808080, 32'h80808080, 0, d, lat);
            if (d !== exp || lat !== P + 1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL wrap_steps: got %0d bad steps expected 0", bad);
        end
        n_cmp++;
        if (d !== 32'h80010000) begin
            n_fail++; $display("FAIL wrap_final: got %h expected %h", d, 32'h80010000);
        end
        void'(model_exec(fid(2, 3), 32'h80808080, 32'h80808080));
        do_cmd(fid(2, 3), 32'h80808080, 32'h80808080, 0, d, lat);
        void'(model_exec(fid(1, 2), 32'd0, 32'd0));
        do_cmd(fid(1, 2), 32'd0, 32'd0, 0, d, lat);
        do_cmd(fid(3, 2), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL clear_one_bank2: got %h expected 0", d);
        end
        do_cmd(fid(3, 3), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'h00030000) begin
            n_fail++; $display("FAIL clear_one_keeps_bank3: got %h expected %h", d, 32'h00030000);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, exp;
        logic [9:0]  f;
        int          lat, r, op;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = 0;
                1:       op = 1;
                6, 7:    op = 3;
                8:       op = $urandom_range(4, 127);
                default: op = 2;
            endcase
            a = $urandom;
            b = $urandom;
            if (op == 1 && $urandom_range(0, 3) != 0) a[31] = 1'b0;
            f   = fid(op, $urandom_range(0, 7));
            exp = model_exec(f, a, b);
            do_cmd(f, a, b, $urandom_range(0, 3), d, lat);
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL rand_rsp[%0d] op %0d: got %h expected %h", n, op, d, exp);
            end
            n_cmp++;
            if (lat !== ((op == 2) ? P + 1 : 1)) begin
                n_fail++; $display("FAIL rand_latency[%0d] op %0d: got %0d expected %0d",
                                   n, op, lat, (op == 2) ? P + 1 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          lat;
        void'(model_exec(fid(0, 0), 32'd0, 32'd0));
        do_cmd(fid(0, 0), 32'd0, 32'd0, 0, d, lat);
        void'(model_exec(fid(1, 3), 32'd0, 32'd0));
        do_cmd(fid(1, 3), 32'd0, 32'd0, 0, d, lat);
        void'(model_exec(fid(2, 3), 32'h01020304, 32'h01010101));
        do_cmd(fid(2, 3), 32'h01020304, 32'h01010101, 0, d, lat);
        n_cmp++;
        if (d !== 32'd10) begin
            n_fail++; $display("FAIL rstmid_prior: got %h expected %h", d, 32'd10);
        end
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = fid(2, 3);
        bus.cmd_payload_inputs_0    = 32'h7F7F7F7F;
        bus.cmd_payload_inputs_1    = 32'h7F7F7F7F;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_state: got valid %b ready %b expected 0 1",
                               bus.rsp_valid, bus.cmd_ready);
        end
        repeat (P + 2) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_late_rsp: got %b expected 0", bus.rsp_valid);
        end
        do_cmd(fid(3, 3), 32'd0, 32'd0, 0, d, lat);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_bank3: got %h expected 0", d);
        end
        do_cmd(fid(2, 0), 32'hFEFEFEFE, 32'h01010101, 0, d, lat);
        n_cmp++;
        if (d !== 32'hFFFFFFF8) begin
            n_fail++; $display("FAIL rstmid_offset_cleared: got %h expected %h", d, 32'hFFFFFFF8);
        end
    endtask

    initial begin
        reset                       = 1'b1;
        bus.cmd_valid               = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0    = '0;
        bus.cmd_payload_inputs_1    = '0;
        bus.rsp_ready               = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_mac_offset();
        test_backpressure();
        test_wrap_clear();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
